// File: rtl/logic_burst_acc_pkg.sv
// Shared types for the burst logic accumulator: operation codes, FSM states
// and the mapping from a requested op to the per-beat/fold base op.
package logic_acc_pkg;

  typedef enum logic [1:0] {OP_OR, OP_AND, OP_XOR, OP_NOR} op_e;

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_HOLD} state_e;

  // NOR folds as OR; the inversion is applied once, to the final result.
  function automatic op_e base_op(input op_e op);
    return (op == OP_NOR) ? OP_OR : op;
  endfunction

endpackage

// File: rtl/logic_burst_acc_if.sv
// Beat input channel and result output channel of the burst accumulator.
// master = operand source / result consumer, slave = the accumulator.
interface logic_burst_acc_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 5
);

  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_last;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_f;
  logic [CNT_W-1:0] out_count;
  logic             out_ovf;

  modport master (
    output in_valid, in_op, in_a, in_b, in_last, out_ready,
    input  in_ready, out_valid, out_f, out_count, out_ovf
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, in_last, out_ready,
    output in_ready, out_valid, out_f, out_count, out_ovf
  );

endinterface

// File: rtl/logic_burst_acc_logic_op.sv
// Combinational bitwise operator: f = a op b for one op_e code.
module logic_op
  import logic_acc_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  op_e              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] f
);

  always_comb begin
    f = '0;
    case (op)
      OP_OR:   f = a | b;
      OP_AND:  f = a & b;
      OP_XOR:  f = a ^ b;
      OP_NOR:  f = ~(a | b);
      default: f = '0;
    endcase
  end

endmodule

// File: rtl/logic_burst_acc.sv
// Burst logic accumulator: folds OR/AND/XOR/NOR of operand pairs across a
// burst of beats and presents one registered result with valid/ready.
module logic_burst_acc
  import logic_acc_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_BEATS = 16
) (
  input logic               clk,
  input logic               rst_n,
  logic_burst_acc_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(MAX_BEATS + 1);

  state_e           state, state_n;
  op_e              op_q, op_n;
  logic [WIDTH-1:0] acc_q, acc_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;

  logic             ready_q, ready_n;
  logic             valid_q, valid_n;
  logic [WIDTH-1:0] f_q, f_n;
  logic [CNT_W-1:0] count_q, count_n;
  logic             ovf_q, ovf_n;

  op_e              beat_op;
  op_e              fold_op;
  logic [WIDTH-1:0] beat_f;
  logic [WIDTH-1:0] fold_f;
  logic             accept;
  logic             close;

  // First beat of a burst uses the incoming op; later beats use the latched one.
  assign beat_op = (state == S_IDLE) ? base_op(op_e'(bus.in_op)) : base_op(op_q);
  assign fold_op = base_op(op_q);
  assign accept  = bus.in_valid & ready_q;

  logic_op #(.WIDTH(WIDTH)) u_beat_op (
    .op (beat_op),
    .a  (bus.in_a),
    .b  (bus.in_b),
    .f  (beat_f)
  );

  logic_op #(.WIDTH(WIDTH)) u_fold_op (
    .op (fold_op),
    .a  (acc_q),
    .b  (beat_f),
    .f  (fold_f)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next state, datapath and output-register next values.
  always_comb begin
    state_n = state;
    op_n    = op_q;
    acc_n   = acc_q;
    cnt_n   = cnt_q;
    close   = 1'b0;
    f_n     = f_q;
    count_n = count_q;
    ovf_n   = ovf_q;

    case (state)
      S_IDLE: begin
        if (accept) begin
          op_n    = op_e'(bus.in_op);
          acc_n   = beat_f;
          cnt_n   = CNT_W'(1);
          close   = bus.in_last || (cnt_n == CNT_W'(MAX_BEATS));
          state_n = S_ACC;
        end
      end
      S_ACC: begin
        if (accept) begin
          acc_n = fold_f;
          cnt_n = cnt_q + CNT_W'(1);
          close = bus.in_last || (cnt_n == CNT_W'(MAX_BEATS));
        end
      end
      S_HOLD: begin
        if (bus.out_ready) begin
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase

    // Closing without in_last can only mean the beat cap was reached.
    if (close) begin
      state_n = S_HOLD;
      f_n     = (op_n == OP_NOR) ? ~acc_n : acc_n;
      count_n = cnt_n;
      ovf_n   = ~bus.in_last;
    end

    valid_n = (state_n == S_HOLD);
    ready_n = (state_n != S_HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= OP_OR;
      acc_q   <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      f_q     <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      op_q    <= op_n;
      acc_q   <= acc_n;
      cnt_q   <= cnt_n;
      ready_q <= ready_n;
      valid_q <= valid_n;
      f_q     <= f_n;
      count_q <= count_n;
      ovf_q   <= ovf_n;
    end
  end

  assign bus.in_ready  = ready_q;
  assign bus.out_valid = valid_q;
  assign bus.out_f     = f_q;
  assign bus.out_count = count_q;
  assign bus.out_ovf   = ovf_q;

endmodule

// File: tb/tb_logic_burst_acc.sv
// Bench for logic_burst_acc (WIDTH=8, MAX_BEATS=4): directed bursts with literal
// results, then random traffic checked every cycle against a burst-level model.
module tb_logic_burst_acc;
  import logic_acc_pkg::*;

  localparam int unsigned WIDTH     = 8;
  localparam int unsigned MAX_BEATS = 4;
  localparam int unsigned CNT_W     = $clog2(MAX_BEATS + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic_burst_acc_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  logic_burst_acc #(.WIDTH(WIDTH), .MAX_BEATS(MAX_BEATS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [7:0] f;
    int         count;
    bit         ovf;
  } res_t;

  res_t       exp_q[$];
  logic [7:0] beat_a[$];
  logic [7:0] beat_b[$];
  logic [1:0] burst_op;
  bit         fresh;
  int         tests = 0;
  int         fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Result of a whole burst straight from the op definitions.
  function automatic logic [7:0] fold_burst(input logic [1:0] op);
    logic [7:0] r;
    r = (op == 2'b01) ? 8'hFF : 8'h00;
    foreach (beat_a[i]) begin
      case (op)
        2'b01:   r = r & beat_a[i] & beat_b[i];
        2'b10:   r = r ^ beat_a[i] ^ beat_b[i];
        default: r = r | beat_a[i] | beat_b[i];
      endcase
    end
    return (op == 2'b11) ? ~r : r;
  endfunction

  // Predict what the next rising edge does, from the model's own state.
  task automatic model_step(input bit v, input logic [1:0] op, input logic [7:0] a,
                            input logic [7:0] b, input bit last, input bit ordy);
    res_t r;
    bit   take;
    take = v && !fresh && (exp_q.size() == 0);
    if (ordy && exp_q.size() != 0) void'(exp_q.pop_front());
    if (take) begin
      if (beat_a.size() == 0) burst_op = op;
      beat_a.push_back(a);
      beat_b.push_back(b);
      if (last || beat_a.size() == MAX_BEATS) begin
        r.f     = fold_burst(burst_op);
        r.count = beat_a.size();
        r.ovf   = !last;
        exp_q.push_back(r);
        beat_a.delete();
        beat_b.delete();
      end
    end
    fresh = 1'b0;
  endtask

  task automatic compare_outputs();
    check("in_ready", 32'(bus.in_ready), 32'(exp_q.size() == 0));
    check("out_valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      check("out_f", 32'(bus.out_f), 32'(exp_q[0].f));
      check("out_count", 32'(bus.out_count), 32'(exp_q[0].count));
      check("out_ovf", 32'(bus.out_ovf), 32'(exp_q[0].ovf));
    end
  endtask

  // One clock: drive inputs, advance the model, then check at the falling edge.
  task automatic tick(input bit v, input logic [1:0] op, input logic [7:0] a,
                      input logic [7:0] b, input bit last, input bit ordy);
    bus.in_valid  = v;
    bus.in_op     = op;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_last   = last;
    bus.out_ready = ordy;
    model_step(v, op, a, b, last, ordy);
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic check_result(input string name, input logic [7:0] f, input int count, input bit ovf);
    check({name, "_model"}, 32'(exp_q.size() != 0 ? exp_q[0].f : 8'h00), 32'(f));
    check({name, "_valid"}, 32'(bus.out_valid), 32'd1);
    check({name, "_f"}, 32'(bus.out_f), 32'(f));
    check({name, "_count"}, 32'(bus.out_count), 32'(count));
    check({name, "_ovf"}, 32'(bus.out_ovf), 32'(ovf));
  endtask

  task automatic check_cleared(input string name);
    check({name, "_in_ready"}, 32'(bus.in_ready), 32'd0);
    check({name, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    check({name, "_out_f"}, 32'(bus.out_f), 32'd0);
    check({name, "_out_count"}, 32'(bus.out_count), 32'd0);
    check({name, "_out_ovf"}, 32'(bus.out_ovf), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_op     = 2'b00;
    bus.in_a      = 8'h00;
    bus.in_b      = 8'h00;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    fresh         = 1'b1;

    #3;
    check_cleared("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick(0, 2'b00, 8'h00, 8'h00, 0, 0);
    check("ready_after_release", 32'(bus.in_ready), 32'd1);

    // Single-beat OR.
    tick(1, 2'b00, 8'hF0, 8'h0F, 1, 0);
    check_result("single_or", 8'hFF, 1, 1'b0);
    tick(0, 2'b00, 8'h00, 8'h00, 0, 1);

    // 3-beat AND with op changed mid-burst.
    tick(1, 2'b01, 8'hFF, 8'hF0, 0, 0);
    tick(1, 2'b10, 8'hF3, 8'hFF, 0, 0);
    tick(1, 2'b10, 8'h7F, 8'hFF, 1, 0);
    check_result("and3", 8'h70, 3, 1'b0);
    tick(0, 2'b00, 8'h00, 8'h00, 0, 1);

    // 2-beat NOR.
    tick(1, 2'b11, 8'h01, 8'h02, 0, 0);
    tick(1, 2'b11, 8'h04, 8'h00, 1, 0);
    check_result("nor2", 8'hF8, 2, 1'b0);
    tick(0, 2'b00, 8'h00, 8'h00, 0, 1);

    // XOR past the beat cap: forced close, then the 5th beat opens a new burst.
    tick(1, 2'b10, 8'h01, 8'h00, 0, 0);
    tick(1, 2'b10, 8'h02, 8'h00, 0, 0);
    tick(1, 2'b10, 8'h04, 8'h00, 0, 0);
    tick(1, 2'b10, 8'h08, 8'h00, 0, 0);
    check_result("xor_cap", 8'h0F, 4, 1'b1);
    tick(1, 2'b10, 8'h10, 8'h00, 1, 1);
    check("beat5_blocked", 32'(bus.out_valid), 32'd0);
    tick(1, 2'b10, 8'h10, 8'h00, 1, 0);
    check_result("beat5_new", 8'h10, 1, 1'b0);
    tick(0, 2'b00, 8'h00, 8'h00, 0, 1);

    // in_last on the cap beat closes normally.
    tick(1, 2'b01, 8'hFF, 8'hFE, 0, 0);
    tick(1, 2'b01, 8'hFD, 8'hFF, 0, 0);
    tick(1, 2'b01, 8'hFF, 8'hFB, 0, 0);
    tick(1, 2'b01, 8'hF7, 8'hFF, 1, 0);
    check_result("and_last_cap", 8'hF0, 4, 1'b0);
    tick(0, 2'b00, 8'h00, 8'h00, 0, 1);

    // Result held through 5 stalled cycles with inputs pending.
    tick(1, 2'b10, 8'hA5, 8'h0F, 1, 0);
    for (int i = 0; i < 5; i++) begin
      tick(1, 2'b00, 8'hFF, 8'hFF, 1, 0);
      check("stall_in_ready", 32'(bus.in_ready), 32'd0);
      check("stall_f", 32'(bus.out_f), 32'hAA);
    end
    tick(0, 2'b00, 8'h00, 8'h00, 0, 1);
    check("stall_released", 32'(bus.out_valid), 32'd0);
    check("stall_idle_ready", 32'(bus.in_ready), 32'd1);

    // Asynchronous reset mid-burst.
    tick(1, 2'b00, 8'h11, 8'h22, 0, 0);
    #2 rst_n = 1'b0;
    #1 check_cleared("async_reset");
    exp_q.delete();
    beat_a.delete();
    beat_b.delete();
    @(negedge clk);
    rst_n = 1'b1;
    fresh = 1'b1;
    tick(0, 2'b00, 8'h00, 8'h00, 0, 0);
    tick(1, 2'b10, 8'h3C, 8'h00, 0, 0);
    tick(1, 2'b11, 8'h00, 8'hC3, 1, 0);
    check_result("post_reset", 8'hFF, 2, 1'b0);
    tick(0, 2'b00, 8'h00, 8'h00, 0, 1);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      tick($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
           8'($urandom), 8'($urandom),
           $urandom_range(0, 4) == 0, $urandom_range(0, 2) != 0);
    end
    repeat (3) tick(0, 2'b00, 8'h00, 8'h00, 0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
